// File: rtl/pipe_feeder_pkg.sv
// Shared definitions for the pipe feeder: default widths, FSM encoding and
// a saturating counter helper.
package pipe_feeder_pkg;

   localparam int DW_DEFAULT = 16;
   localparam int AW_DEFAULT = 8;
   localparam int STALL_W    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (v == {STALL_W{1'b1}}) ? v : v + {{(STALL_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/operand_fifo2.sv
// Two-entry shift-style FIFO: slot 0 is always the head, so the head holds
// the last popped value once the FIFO runs empty.
module operand_fifo2
   import pipe_feeder_pkg::*;
#(
   parameter int W = 2 * DW_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [1:0]   count,
   output logic [W-1:0] head
);

   logic [W-1:0] r_slot0;
   logic [W-1:0] r_slot1;
   logic [1:0]   r_count;
   logic         w_pop;
   logic         w_push;

   assign w_pop  = pop && (r_count != 2'd0);
   assign w_push = push && ((r_count != 2'd2) || w_pop);

   // NOTE: the data slots are reset too, because the head drives op_a/op_b
   // directly and those must read zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slot0 <= '0;
         r_slot1 <= '0;
         r_count <= 2'd0;
      end else begin
         case (r_count)
            2'd0: begin
               if (w_push) r_slot0 <= din;
            end
            2'd1: begin
               if (w_push && w_pop)  r_slot0 <= din;
               else if (w_push)      r_slot1 <= din;
            end
            default: begin
               if (w_pop) begin
                  r_slot0 <= r_slot1;
                  if (w_push) r_slot1 <= din;
               end
            end
         endcase

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign count = r_count;
   assign head  = r_slot0;

endmodule

// File: rtl/pipe_feeder.sv
// Feeds operand pairs from the operand buffer into the multiply/add pipe,
// keeping at most two pairs buffered or in flight at any time.
module pipe_feeder
   import pipe_feeder_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int AW = AW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          go,
   input  logic [AW-1:0] len,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata_a,
   input  logic [DW-1:0] mem_rdata_b,
   output logic          start,
   output logic          can_mult,
   output logic [DW-1:0] op_a,
   output logic [DW-1:0] op_b,
   input  logic          ld_mult,
   input  logic          ld_add,
   input  logic          pipe_stall,
   output logic          busy,
   output logic          done,
   output logic [15:0]   stall_cnt
);

   localparam logic [AW-1:0] ONE = AW'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [AW-1:0]       r_len;
   logic [AW-1:0]       r_issued;
   logic [AW-1:0]       r_consumed;
   logic                r_inflight;
   logic [STALL_W-1:0]  r_stall_cnt;

   logic [1:0]          w_count;
   logic [2*DW-1:0]     w_head;
   logic                w_pop;
   logic [2:0]          w_occ;
   logic                w_rd_ok;
   logic                w_job_go;

   assign can_mult = (r_state == FEED) && (w_count != 2'd0);
   assign w_pop    = ld_mult && can_mult;
   assign w_job_go = (r_state == IDLE) && go && (len != '0);

   // Occupancy after this cycle's pop, counting the read still in flight.
   assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_rd_ok = (r_issued < r_len) && (w_occ < 3'd2);

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      mem_rd      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (go) w_state_nxt = (len != '0) ? FEED : DONE;
         end
         FEED: begin
            busy   = 1'b1;
            mem_rd = w_rd_ok;
            if (w_pop && ((r_consumed + ONE) == r_len)) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (ld_add && !ld_mult) w_state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: all state updates are non-blocking so every register samples the
   // pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_issued    <= '0;
         r_consumed  <= '0;
         r_inflight  <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= mem_rd;
         if (w_job_go) begin
            r_len       <= len;
            r_issued    <= '0;
            r_consumed  <= '0;
            r_stall_cnt <= '0;
         end else begin
            if (mem_rd) r_issued   <= r_issued + ONE;
            if (w_pop)  r_consumed <= r_consumed + ONE;
            if (busy && pipe_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
         end
      end
   end

   // Returning read data lands in the FIFO the cycle after its strobe.
   operand_fifo2 #(
      .W (2 * DW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r_inflight),
      .pop   (w_pop),
      .din   ({mem_rdata_a, mem_rdata_b}),
      .count (w_count),
      .head  (w_head)
   );

   assign mem_addr  = r_issued;
   assign start     = busy;
   assign op_a      = w_head[2*DW-1:DW];
   assign op_b      = w_head[DW-1:0];
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_feeder.sv
// Self-checking bench for pipe_feeder: a directed vector table, hand-written
// corner sequences and randomized jobs checked against a job-level model.
module tb_pipe_feeder;

   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int BOUND = 4000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          go = 1'b0;
   logic [AW-1:0] len = '0;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata_a = '0;
   logic [DW-1:0] mem_rdata_b = '0;
   logic          start;
   logic          can_mult;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic          ld_mult = 1'b0;
   logic          ld_add = 1'b0;
   logic          pipe_stall = 1'b0;
   logic          busy;
   logic          done;
   logic [15:0]   stall_cnt;

   pipe_feeder #(.DW(DW), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .go          (go),
      .len         (len),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_rdata_a (mem_rdata_a),
      .mem_rdata_b (mem_rdata_b),
      .start       (start),
      .can_mult    (can_mult),
      .op_a        (op_a),
      .op_b        (op_b),
      .ld_mult     (ld_mult),
      .ld_add      (ld_add),
      .pipe_stall  (pipe_stall),
      .busy        (busy),
      .done        (done),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   // Operand buffer: one-cycle read latency.
   logic [DW-1:0] mem_a [256];
   logic [DW-1:0] mem_b [256];

   always @(posedge clk) begin
      if (mem_rd) begin
         mem_rdata_a <= mem_a[mem_addr];
         mem_rdata_b <= mem_b[mem_addr];
      end
   end

   int n_vec = 0;
   int n_err = 0;
   int dut_pops = 0;

   // Job-level reference model.
   bit          m_active;
   bit          m_done_pend;
   bit          m_rd_last;
   int          m_len;
   int          m_iss;
   int          m_cons;
   logic [15:0] m_stall;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active    = 1'b0;
      m_done_pend = 1'b0;
      m_rd_last   = 1'b0;
      m_len       = 0;
      m_iss       = 0;
      m_cons      = 0;
      m_stall     = '0;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = DW'($urandom);
         mem_b[i] = DW'($urandom);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_mem_rd",    32'(mem_rd),    32'd0);
      check("rst_start",     32'(start),     32'd0);
      check("rst_can_mult",  32'(can_mult),  32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_op_a",      32'(op_a),      32'd0);
      check("rst_op_b",      32'(op_b),      32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
   endtask

   // One clock cycle: drive at negedge, check against the model, advance it.
   // mmode: 0 ld_mult low, 1 ld_mult tied to can_mult, 2 ld_mult high.
   task automatic cyc(input bit i_go, input int i_len, input int mmode,
                      input bit i_add, input bit i_stall);
      bit idle, feeding, draining, exp_can, pop, exp_rd, nxt_done;
      int avail;
      @(negedge clk);
      go         = i_go;
      len        = AW'(i_len);
      ld_add     = i_add;
      pipe_stall = i_stall;
      case (mmode)
         0:       ld_mult = 1'b0;
         1:       ld_mult = can_mult;
         default: ld_mult = 1'b1;
      endcase
      #1;
      idle     = !m_active && !m_done_pend;
      feeding  = m_active && (m_cons < m_len);
      draining = m_active && (m_cons >= m_len);
      // Pairs whose data has already returned but not yet been consumed.
      avail    = m_iss - int'(m_rd_last) - m_cons;
      exp_can  = feeding && (avail > 0);
      pop      = ld_mult && exp_can;
      exp_rd   = feeding && (m_iss < m_len) && ((m_iss - m_cons - int'(pop)) < 2);

      check("busy",      32'(busy),      32'(m_active));
      check("start",     32'(start),     32'(m_active));
      check("done",      32'(done),      32'(m_done_pend));
      check("mem_rd",    32'(mem_rd),    32'(exp_rd));
      if (exp_rd && mem_rd) check("mem_addr", 32'(mem_addr), 32'(m_iss[AW-1:0]));
      check("can_mult",  32'(can_mult),  32'(exp_can));
      if (exp_can && can_mult) begin
         check("op_a", 32'(op_a), 32'(mem_a[m_cons[AW-1:0]]));
         check("op_b", 32'(op_b), 32'(mem_b[m_cons[AW-1:0]]));
      end
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (ld_mult && can_mult) dut_pops++;

      nxt_done = 1'b0;
      if (idle && i_go) begin
         if (i_len != 0) begin
            m_active  = 1'b1;
            m_len     = i_len;
            m_iss     = 0;
            m_cons    = 0;
            m_rd_last = 1'b0;
            m_stall   = '0;
         end else begin
            nxt_done = 1'b1;
         end
      end else begin
         if (m_active && i_stall && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
         m_iss     = m_iss + int'(exp_rd);
         m_rd_last = exp_rd;
         m_cons    = m_cons + int'(pop);
         if (draining && i_add && !ld_mult) begin
            m_active = 1'b0;
            nxt_done = 1'b1;
         end
      end
      m_done_pend = nxt_done;
   endtask

   // Run cycles until the model says the job is over; mmode < 0 = random controller.
   task automatic finish_job(input int mmode, input bit rand_go);
      int n = 0;
      while ((m_active || m_done_pend) && (n < BOUND)) begin
         if (mmode < 0)
            cyc(rand_go && ($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0));
         else
            cyc(1'b0, 0, mmode, 1'b1, 1'b0);
         n++;
      end
      check("job_bound", 32'(n < BOUND), 32'd1);
   endtask

   task automatic check_job_end(input int jlen);
      check("pairs", 32'(dut_pops), 32'(jlen));
      if (jlen > 0) begin
         check("op_a_hold", 32'(op_a), 32'(mem_a[jlen-1]));
         check("op_b_hold", 32'(op_b), 32'(mem_b[jlen-1]));
      end
   endtask

   typedef struct {
      logic          go;
      logic [AW-1:0] len;
      logic          add;
      logic          rd;
      logic [AW-1:0] addr;
      logic          can;
      logic          busy;
      logic          done;
      int            op_idx;
   } vec_t;

   vec_t tbl [10];

   initial begin
      // len=4 job with ld_mult tied to can_mult, cycle by cycle from go.
      tbl[0] = '{1'b1, 8'd4, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, -1};
      tbl[1] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, -1};
      tbl[2] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, -1};
      tbl[3] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0,  0};
      tbl[4] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0,  1};
      tbl[5] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0,  2};
      tbl[6] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0,  3};
      tbl[7] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, -1};
      tbl[8] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, -1};
      tbl[9] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, -1};
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 16'hA000 | DW'(i);
         mem_b[i] = 16'hB000 | DW'(i);
      end
      model_reset();

      repeat (2) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         go         = tbl[i].go;
         len        = tbl[i].len;
         ld_add     = tbl[i].add;
         pipe_stall = 1'b0;
         ld_mult    = can_mult;
         #1;
         check("tbl_mem_rd",   32'(mem_rd),   32'(tbl[i].rd));
         if (tbl[i].rd) check("tbl_mem_addr", 32'(mem_addr), 32'(tbl[i].addr));
         check("tbl_can_mult", 32'(can_mult), 32'(tbl[i].can));
         check("tbl_busy",     32'(busy),     32'(tbl[i].busy));
         check("tbl_start",    32'(start),    32'(tbl[i].busy));
         check("tbl_done",     32'(done),     32'(tbl[i].done));
         if (tbl[i].op_idx >= 0) begin
            check("tbl_op_a", 32'(op_a), 32'(mem_a[tbl[i].op_idx]));
            check("tbl_op_b", 32'(op_b), 32'(mem_b[tbl[i].op_idx]));
         end
      end
      check("tbl_op_hold", 32'(op_a), 32'h0000_A003);

      // len=0: done next cycle, no reads, never busy.
      fill_mem();
      dut_pops = 0;
      cyc(1'b1, 0, 1, 1'b0, 1'b0);
      cyc(1'b0, 0, 2, 1'b0, 1'b0);
      cyc(1'b0, 0, 2, 1'b0, 1'b0);
      check("len0_pairs", 32'(dut_pops), 32'd0);

      // len=5 with ld_mult low for three cycles: FIFO fills, nothing lost.
      fill_mem();
      dut_pops = 0;
      cyc(1'b1, 5, 1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 0, 1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 0, 0, 1'b0, 1'b0);
      finish_job(1, 1'b0);
      check_job_end(5);

      // Two stall cycles at job start; stall in IDLE is not counted.
      fill_mem();
      dut_pops = 0;
      cyc(1'b1, 3, 1, 1'b0, 1'b1);
      repeat (2) cyc(1'b0, 0, 1, 1'b0, 1'b1);
      finish_job(1, 1'b0);
      check("stall_after_done", 32'(stall_cnt), 32'd2);
      repeat (3) cyc(1'b0, 0, 0, 1'b0, 1'b1);
      check("stall_held", 32'(stall_cnt), 32'd2);
      check_job_end(3);

      // go during FEED is ignored.
      fill_mem();
      dut_pops = 0;
      cyc(1'b1, 4, 1, 1'b0, 1'b0);
      cyc(1'b0, 0, 1, 1'b0, 1'b0);
      cyc(1'b1, 9, 1, 1'b0, 1'b0);
      finish_job(1, 1'b0);
      check_job_end(4);

      // Reset mid-FEED with a read in flight, then a clean len=2 job.
      fill_mem();
      cyc(1'b1, 6, 0, 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check_reset_outputs();
      model_reset();
      #1 rst = 1'b0;
      repeat (2) cyc(1'b0, 0, 2, 1'b1, 1'b0);
      fill_mem();
      dut_pops = 0;
      cyc(1'b1, 2, 1, 1'b0, 1'b0);
      finish_job(1, 1'b0);
      check_job_end(2);

      // Maximum-length job at full rate.
      fill_mem();
      dut_pops = 0;
      cyc(1'b1, 255, 1, 1'b0, 1'b0);
      finish_job(1, 1'b0);
      check_job_end(255);

      // Randomized jobs with a random controller and stray go pulses.
      for (int j = 0; j < 16; j++) begin
         int jl;
         jl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
         fill_mem();
         dut_pops = 0;
         cyc(1'b1, jl, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 0));
         finish_job(-1, 1'b1);
         check_job_end(jl);
         repeat (int'($urandom_range(0, 3)))
            cyc(1'b0, 0, int'($urandom_range(0, 3)), 1'b0, bit'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
